// File: rtl/lc_bank_ctrl_if.sv
// CPU-side bus and RAM-mapping outputs of the language card bank controller.
// The CPU/decode side is the master; the controller is the slave.
interface lc_bank_ctrl_if #(
  parameter int BANK_BITS = 3,
  parameter int ADDR_W    = 18
) ();
  logic                 strobe;
  logic [15:0]          addr;
  logic                 we;
  logic [ADDR_W-1:0]    ram_addr;
  logic                 card_ram_rd;
  logic                 card_ram_we;
  logic                 bank1;
  logic [BANK_BITS-1:0] bank_sel;
  logic                 card_active;

  modport master (
    output strobe, addr, we,
    input  ram_addr, card_ram_rd, card_ram_we, bank1, bank_sel, card_active
  );

  modport slave (
    input  strobe, addr, we,
    output ram_addr, card_ram_rd, card_ram_we, bank1, bank_sel, card_active
  );
endinterface

// File: rtl/lc_bank_ctrl.sv
// Language Card / Saturn bank-switching controller: soft-switch decode in one
// slot page, two-read write-enable FSM, and $D000-$FFFF -> card RAM mapping.
//
// wstate   | meaning
// ---------+---------------------------------------------------------------
// WS_WP    | card RAM write-protected
// WS_ARMED | one odd-address read seen; a second one enables writes
// WS_WE    | writes to $D000-$FFFF go to card RAM
module lc_bank_ctrl #(
  parameter int              SLOT      = 1,
  parameter int              BANK_BITS = 3,
  parameter bit              SATURN    = 1'b1,
  parameter longint unsigned BASE      = 64'h10000,
  parameter int              ADDR_W    = 18
) (
  input  logic          mclk28,
  input  logic          reset_in,
  lc_bank_ctrl_if.slave bus
);

  localparam longint unsigned BANK_SPAN = 64'd1 << (BANK_BITS + 14);
  localparam longint unsigned ADDR_SPAN = 64'd1 << ADDR_W;

  if (SLOT < 0 || SLOT > 7) begin : g_bad_slot
    $error("lc_bank_ctrl: SLOT must be 0..7");
  end
  if (BANK_BITS < 1 || BANK_BITS > 4) begin : g_bad_bank_bits
    $error("lc_bank_ctrl: BANK_BITS must be 1..4");
  end
  if (ADDR_W < 1 || ADDR_W > 62 || BASE + BANK_SPAN > ADDR_SPAN) begin : g_bad_span
    $error("lc_bank_ctrl: BASE + bank span does not fit in ADDR_W bits");
  end

  typedef enum logic [1:0] {
    WS_WP    = 2'd0,
    WS_ARMED = 2'd1,
    WS_WE    = 2'd2
  } wstate_t;

  localparam logic [11:0]       PAGE   = 12'hC08 + 12'(SLOT);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  logic                 strobe_d;
  wstate_t              wstate_q, wstate_nxt;
  logic                 read_en_q, read_en_nxt;
  logic                 bank1_q, bank1_nxt;
  logic [BANK_BITS-1:0] bank_sel_q, bank_sel_nxt;

  logic access_ev;
  logic bank_ev;
  logic mode_ev;

  // One event per strobe high period, only within our slot page.
  assign access_ev = bus.strobe & ~strobe_d & (bus.addr[15:4] == PAGE);
  assign bank_ev   = access_ev & SATURN & bus.addr[2];
  assign mode_ev   = access_ev & ~(SATURN & bus.addr[2]);

  always_ff @(posedge mclk28) begin
    strobe_d <= bus.strobe;
    if (reset_in) begin
      wstate_q   <= WS_WE;
      read_en_q  <= 1'b0;
      bank1_q    <= 1'b0;
      bank_sel_q <= '0;
    end else begin
      wstate_q   <= wstate_nxt;
      read_en_q  <= read_en_nxt;
      bank1_q    <= bank1_nxt;
      bank_sel_q <= bank_sel_nxt;
    end
  end

  always_comb begin
    wstate_nxt   = wstate_q;
    read_en_nxt  = read_en_q;
    bank1_nxt    = bank1_q;
    bank_sel_nxt = bank_sel_q;

    if (bank_ev) begin
      bank_sel_nxt = BANK_BITS'({bus.addr[3], bus.addr[1], bus.addr[0]});
    end

    if (mode_ev) begin
      bank1_nxt   = bus.addr[3];
      read_en_nxt = ~(bus.addr[0] ^ bus.addr[1]);
      if (!bus.addr[0]) begin
        wstate_nxt = WS_WP;
      end else if (!bus.we) begin
        case (wstate_q)
          WS_WP:    wstate_nxt = WS_ARMED;
          WS_ARMED: wstate_nxt = WS_WE;
          default:  wstate_nxt = WS_WE;
        endcase
      end else if (wstate_q == WS_ARMED) begin
        // A write between the two reads breaks the arming sequence.
        wstate_nxt = WS_WP;
      end
    end
  end

  logic                 card_ram_we_w;
  logic                 card_active_w;
  logic                 in_window;
  logic                 is_d_page;
  logic [13:0]          offset;
  logic [ADDR_W-1:0]    bank_base;

  assign card_ram_we_w = (wstate_q == WS_WE);
  assign card_active_w = read_en_q | card_ram_we_w;
  assign in_window     = (bus.addr[15:12] >= 4'hD);
  assign is_d_page     = (bus.addr[15:12] == 4'hD);

  // $Dxxx bank 2 lives at offset $1000, bank 1 overlays $0000 within the 16K.
  assign offset    = {bus.addr[13], bus.addr[12] & ~(bank1_q & is_d_page), bus.addr[11:0]};
  assign bank_base = ADDR_W'({bank_sel_q, 14'd0});

  assign bus.ram_addr    = (card_active_w && in_window) ? (BASE_A + bank_base + ADDR_W'(offset))
                                                        : ADDR_W'(bus.addr);
  assign bus.card_ram_rd = read_en_q;
  assign bus.card_ram_we = card_ram_we_w;
  assign bus.bank1       = bank1_q;
  assign bus.bank_sel    = bank_sel_q;
  assign bus.card_active = card_active_w;

endmodule

// File: tb/tb_lc_bank_ctrl.sv
// Scoreboard bench: three controller configurations share one CPU bus and are
// checked against a behavioural model of the language card soft switches.
module tb_lc_bank_ctrl;

  logic        mclk28 = 1'b0;
  logic        reset_in = 1'b1;
  logic        strobe = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        we = 1'b0;

  always #5 mclk28 = ~mclk28;

  lc_bank_ctrl_if #(.BANK_BITS(3), .ADDR_W(18)) bus0 ();
  lc_bank_ctrl_if #(.BANK_BITS(2), .ADDR_W(18)) bus1 ();
  lc_bank_ctrl_if #(.BANK_BITS(3), .ADDR_W(18)) bus2 ();

  assign bus0.strobe = strobe;
  assign bus0.addr   = addr;
  assign bus0.we     = we;
  assign bus1.strobe = strobe;
  assign bus1.addr   = addr;
  assign bus1.we     = we;
  assign bus2.strobe = strobe;
  assign bus2.addr   = addr;
  assign bus2.we     = we;

  lc_bank_ctrl #(.SLOT(1), .BANK_BITS(3), .SATURN(1'b1), .BASE(64'h10000), .ADDR_W(18))
    u_dut0 (.mclk28(mclk28), .reset_in(reset_in), .bus(bus0));
  lc_bank_ctrl #(.SLOT(1), .BANK_BITS(2), .SATURN(1'b1), .BASE(64'h10000), .ADDR_W(18))
    u_dut1 (.mclk28(mclk28), .reset_in(reset_in), .bus(bus1));
  lc_bank_ctrl #(.SLOT(1), .BANK_BITS(3), .SATURN(1'b0), .BASE(64'h10000), .ADDR_W(18))
    u_dut2 (.mclk28(mclk28), .reset_in(reset_in), .bus(bus2));

  // Reference model: write enable = two consecutive odd-address reads.
  int cfg_bb[3]  = '{3, 2, 3};
  bit cfg_sat[3] = '{1'b1, 1'b1, 1'b0};
  bit m_wen[3];
  int m_odd_reads[3];
  bit m_rd[3];
  bit m_b1[3];
  int m_bs[3];

  typedef struct {
    int          dut;
    logic [17:0] ra;
    bit          rd;
    bit          wen;
    bit          b1;
    int          bs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m_wen[d] = 1'b1;
      m_odd_reads[d] = 0;
      m_rd[d] = 1'b0;
      m_b1[d] = 1'b0;
      m_bs[d] = 0;
    end
  endfunction

  function automatic void model_event(input logic [15:0] a, input bit w);
    if (a[15:4] != 12'hC09) return;
    for (int d = 0; d < 3; d++) begin
      if (cfg_sat[d] && a[2]) begin
        m_bs[d] = (a[3] * 4 + a[1] * 2 + a[0]) % (1 << cfg_bb[d]);
      end else begin
        m_b1[d] = a[3];
        m_rd[d] = (a[0] == a[1]);
        if (!a[0]) begin
          m_wen[d] = 1'b0;
          m_odd_reads[d] = 0;
        end else if (!w) begin
          m_odd_reads[d] = m_odd_reads[d] + 1;
          if (m_odd_reads[d] >= 2) m_wen[d] = 1'b1;
        end else if (!m_wen[d]) begin
          m_odd_reads[d] = 0;
        end
      end
    end
  endfunction

  function automatic logic [17:0] exp_ra(input int d, input logic [15:0] p);
    int off;
    if ((m_wen[d] || m_rd[d]) && p >= 16'hD000) begin
      if (p < 16'hE000 && m_b1[d]) off = int'(p) - 'hD000;
      else                         off = int'(p) - 'hC000;
      return 18'('h10000 + m_bs[d] * 16384 + off);
    end
    return 18'(p);
  endfunction

  function automatic void push_exp(input logic [15:0] p);
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      e.dut = d;
      e.ra  = exp_ra(d, p);
      e.rd  = m_rd[d];
      e.wen = m_wen[d];
      e.b1  = m_b1[d];
      e.bs  = m_bs[d];
      exp_q.push_back(e);
    end
  endfunction

  function automatic void chk(input string name, input int d, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s dut%0d addr=%h: got %0h, expected %0h", name, d, addr, act, req);
    end
  endfunction

  // Monitor: outputs are stable by the falling edge after each probe.
  always @(negedge mclk28) begin
    exp_t        e;
    logic [17:0] a_ra;
    bit          a_rd, a_we, a_b1, a_act;
    int          a_bs;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.dut)
        0: begin a_ra = bus0.ram_addr; a_rd = bus0.card_ram_rd; a_we = bus0.card_ram_we;
                 a_b1 = bus0.bank1; a_bs = int'(bus0.bank_sel); a_act = bus0.card_active; end
        1: begin a_ra = bus1.ram_addr; a_rd = bus1.card_ram_rd; a_we = bus1.card_ram_we;
                 a_b1 = bus1.bank1; a_bs = int'(bus1.bank_sel); a_act = bus1.card_active; end
        default: begin a_ra = bus2.ram_addr; a_rd = bus2.card_ram_rd; a_we = bus2.card_ram_we;
                 a_b1 = bus2.bank1; a_bs = int'(bus2.bank_sel); a_act = bus2.card_active; end
      endcase
      chk("ram_addr",    e.dut, longint'(a_ra),  longint'(e.ra));
      chk("card_ram_rd", e.dut, longint'(a_rd),  longint'(e.rd));
      chk("card_ram_we", e.dut, longint'(a_we),  longint'(e.wen));
      chk("bank1",       e.dut, longint'(a_b1),  longint'(e.b1));
      chk("bank_sel",    e.dut, longint'(a_bs),  longint'(e.bs));
      chk("card_active", e.dut, longint'(a_act), longint'(e.rd | e.wen));
    end
  end

  task automatic access(input logic [15:0] a, input bit w, input int hold,
                        input bit rst, input logic [15:0] probe);
    @(posedge mclk28); #1;
    addr = a; we = w; strobe = 1'b1; reset_in = rst;
    @(posedge mclk28); #1;
    reset_in = 1'b0;
    if (rst) model_reset();
    else     model_event(a, w);
    for (int i = 1; i < hold; i++) begin
      @(posedge mclk28); #1;
    end
    strobe = 1'b0; we = 1'b0; addr = probe;
    push_exp(probe);
  endtask

  task automatic idle_probe(input logic [15:0] probe);
    @(posedge mclk28); #1;
    addr = probe;
    push_exp(probe);
  endtask

  function automatic logic [15:0] rand_probe();
    if ($urandom_range(0, 4) == 0) return 16'($urandom_range(0, 16'hBFFF));
    return 16'(16'hD000 + $urandom_range(0, 16'h2FFF));
  endfunction

  function automatic logic [15:0] rand_switch();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 16'(16'hC090 + $urandom_range(0, 15));
    if (r < 8) return 16'(16'hC080 + $urandom_range(0, 15));
    return 16'($urandom);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge mclk28);
    #1 reset_in = 1'b0;
    idle_probe(16'hE000);

    access(16'hC092, 1'b0, 1, 1'b0, 16'hD800);
    access(16'hC091, 1'b0, 5, 1'b0, 16'hE100);
    access(16'hC091, 1'b0, 1, 1'b0, 16'hF200);
    access(16'hC093, 1'b0, 2, 1'b0, 16'hD123);
    access(16'hC090, 1'b1, 1, 1'b0, 16'hE000);
    access(16'hC091, 1'b0, 1, 1'b0, 16'hE000);
    access(16'hC091, 1'b1, 1, 1'b0, 16'hE000);
    access(16'hC091, 1'b0, 1, 1'b0, 16'hE000);
    access(16'hC090, 1'b0, 1, 1'b0, 16'hD000);
    access(16'hC092, 1'b1, 1, 1'b0, 16'hD000);
    access(16'hC095, 1'b0, 1, 1'b0, 16'hD123);
    access(16'hC09B, 1'b0, 1, 1'b0, 16'hD123);
    access(16'hC093, 1'b0, 1, 1'b0, 16'hD123);
    idle_probe(16'hE456);
    idle_probe(16'h0800);
    access(16'hC09D, 1'b0, 1, 1'b0, 16'hFFFF);
    access(16'hC090, 1'b0, 1, 1'b0, 16'hE000);
    access(16'hC091, 1'b0, 1, 1'b0, 16'hE000);
    access(16'hC091, 1'b0, 1, 1'b1, 16'hE000);
    access(16'hC081, 1'b0, 1, 1'b0, 16'hD000);
    access(16'hC08B, 1'b1, 3, 1'b0, 16'hD000);

    for (int n = 0; n < 400; n++) begin
      access(rand_switch(), 1'($urandom_range(0, 1)), $urandom_range(1, 5),
             ($urandom_range(0, 39) == 0), rand_probe());
    end

    repeat (2) @(posedge mclk28);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
